i2c_req_sequencer: RTL and testbench
====================================

I2C_REQ_SEQUENCER -- requirements
Module: i2c_req_sequencer

Interface
REQ-001 The block SHALL have parameter TimeoutCycles, default 1000000: the per-command watchdog limit in i_clk cycles, used only with I2C_REQ_SEQ_TIMEOUT_EN.
REQ-002 The block SHALL have i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have i_rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-004 The block SHALL have i_req_valid, input, 1 bit: request valid.
REQ-005 The block SHALL have o_req_ready, output, 1 bit: request ready.
REQ-006 The block SHALL have i_req_slave_address, input, 7 bits: the 7-bit I2C slave address.
REQ-007 The block SHALL have i_req_reg_address, input, 8 bits: the slave register address.
REQ-008 The block SHALL have i_req_burst_count, input, 2 bits: byte count N = value+1 (1..4).
REQ-009 The block SHALL have i_req_wdata, input, 32 bits: write byte k on bits [8k+7:8k].
REQ-010 The block SHALL have i_req_rd_wrn, input, 1 bit: 1 = read, 0 = write.
REQ-011 The block SHALL have o_rsp_valid, output, 1 bit: response valid.
REQ-012 The block SHALL have i_rsp_ready, input, 1 bit: response ready.
REQ-013 The block SHALL have o_rsp_rdata, output, 32 bits: read byte k on bits [8k+7:8k].
REQ-014 The block SHALL have o_rsp_err, output, 1 bit: transaction failed (NACK or timeout).
REQ-015 The block SHALL have o_cmd_valid, output, 1 bit: byte-engine command valid.
REQ-016 The block SHALL have i_cmd_ready, input, 1 bit: byte engine accepts the command.
REQ-017 The block SHALL have o_cmd_op, output, 3 bits: the command opcode (0 START, 1 RESTART, 2 WRITE, 3 READ, 4 STOP).
REQ-018 The block SHALL have o_cmd_wdata, output, 8 bits: the byte for a WRITE command.
REQ-019 The block SHALL have o_cmd_last, output, 1 bit: on a READ, the master NACKs the byte.
REQ-020 The block SHALL have i_cmd_done, i_cmd_rdata and i_cmd_nack, inputs of 1, 8 and 1 bits: a one-cycle completion pulse, the READ byte, and the WRITE NACK flag, each qualified by i_cmd_done.
REQ-021 The block SHALL have o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-022 The block SHALL use four states: IDLE, ISSUE, WAIT and RESP.
REQ-023 o_req_ready SHALL be 1 only in IDLE, with i_rst_n=1.
REQ-024 On a request handshake, the block SHALL capture all request fields, clear o_rsp_rdata and o_rsp_err, and go to ISSUE.
REQ-025 A write SHALL issue START, WRITE {sa,0}, WRITE reg, WRITE wdata byte 0..N-1, STOP.
REQ-026 A read SHALL issue START, WRITE {sa,0}, WRITE reg, RESTART, WRITE {sa,1}, READ ×N, STOP.
REQ-027 On a read, o_cmd_last SHALL be 1 on the final READ only; it SHALL be 0 on all other commands.
REQ-028 In ISSUE, o_cmd_valid SHALL be 1, with o_cmd_op, o_cmd_wdata and o_cmd_last held stable until i_cmd_ready; the handshake cycle moves the block to WAIT.
REQ-029 Only one command SHALL be outstanding at a time.
REQ-030 In WAIT, i_cmd_done SHALL advance to the next command (back to ISSUE), or to RESP after STOP; i_cmd_done outside WAIT SHALL be ignored.
REQ-031 On i_cmd_done for READ k, the block SHALL store i_cmd_rdata into o_rsp_rdata byte k; unread bytes stay 0, and a write returns 0.
REQ-032 i_cmd_nack=1 with i_cmd_done on a WRITE SHALL set o_rsp_err=1, skip the remaining commands, and issue STOP next; i_cmd_nack SHALL be ignored on other ops.
REQ-033 In RESP, o_rsp_valid SHALL be 1 with rdata and err stable until i_rsp_ready; the handshake returns to IDLE, so o_req_ready is 1 the next cycle.
REQ-034 i_req_valid while not in IDLE SHALL be ignored, and requests SHALL NOT overlap.
REQ-035 The first o_cmd_valid SHALL assert the cycle after request acceptance.

Reset
REQ-036 While i_rst_n=0 at a clock edge, the state SHALL go to IDLE and o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_cmd_valid, o_cmd_op, o_cmd_wdata, o_cmd_last and o_busy SHALL all be 0.
REQ-037 A reset mid-transaction SHALL abandon it with no STOP and no response; the byte engine shares i_rst_n.

Configuration
REQ-038 With I2C_REQ_SEQ_TIMEOUT_EN defined, a cycle counter SHALL clear at each entry to ISSUE; reaching TimeoutCycles in ISSUE or WAIT SHALL drop o_cmd_valid, set o_rsp_err=1, and go straight to RESP with no STOP.
REQ-039 Without I2C_REQ_SEQ_TIMEOUT_EN, the counter SHALL be absent, the block SHALL wait indefinitely, and o_rsp_err SHALL come only from a NACK.

Verification
REQ-040 Write sa=0x74, reg=0x00, burst=0, wdata=0x08 -> ops START, W 0xE8, W 0x00, W 0x08, STOP; response err=0, rdata=0.
REQ-041 Read sa=0x5D, reg=0x07, burst=3, engine bytes 01,02,03,04 -> RESTART then W 0xBB; last=1 only on the 4th READ; rdata=0x04030201.
REQ-042 Write with i_cmd_nack=1 on W {sa,0} -> next op STOP, no data bytes sent; err=1.
REQ-043 i_cmd_ready held low 20 cycles, then i_rsp_ready low 10 cycles -> cmd fields and rsp fields stable throughout; a second i_req_valid is not accepted meanwhile.
REQ-044 Reset asserted during the 3rd READ -> all outputs 0 next cycle, no response; o_req_ready=1 after release.
REQ-045 With TIMEOUT_EN and TimeoutCycles=50, no i_cmd_done -> o_rsp_valid=1 with err=1 at cycle 50 of WAIT; without the macro, still in WAIT at cycle 1000.

Source files
------------

// File: rtl/i2c_req_sequencer.sv
// Turns one I2C register read/write request into a START/WRITE/RESTART/READ/STOP command stream.
// Optional per-command watchdog enabled by defining I2C_REQ_SEQ_TIMEOUT_EN.
module i2c_req_sequencer #(
    parameter int unsigned TimeoutCycles = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [6:0]  i_req_slave_address,
    input  logic [7:0]  i_req_reg_address,
    input  logic [1:0]  i_req_burst_count,
    input  logic [31:0] i_req_wdata,
    input  logic        i_req_rd_wrn,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic [2:0]  o_cmd_op,
    output logic [7:0]  o_cmd_wdata,
    output logic        o_cmd_last,
    input  logic        i_cmd_done,
    input  logic [7:0]  i_cmd_rdata,
    input  logic        i_cmd_nack,
    output logic        o_busy
);

    localparam logic [2:0] OpStart   = 3'd0;
    localparam logic [2:0] OpRestart = 3'd1;
    localparam logic [2:0] OpWrite   = 3'd2;
    localparam logic [2:0] OpRead    = 3'd3;
    localparam logic [2:0] OpStop    = 3'd4;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
    typedef enum logic [2:0] {PhStart, PhAddrW, PhReg, PhRestart, PhAddrR, PhData, PhStop} phase_e;

    state_e      state_q;
    phase_e      phase_q, nxt_phase;
    logic [1:0]  idx_q, nxt_idx;
    logic [6:0]  sa_q;
    logic [7:0]  reg_q;
    logic [1:0]  burst_q;
    logic [31:0] wdata_q;
    logic        rd_q;
    logic        is_nack;
    logic        timeout_hit;
    logic [2:0]  nxt_op;
    logic [7:0]  nxt_wdata;
    logic        nxt_last;

`ifdef I2C_REQ_SEQ_TIMEOUT_EN
    logic [31:0] tcnt_q;

    // Cleared while idle and on every return to ISSUE, so each command gets a full budget.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tcnt_q <= '0;
        end else if (state_q == StIdle ||
                     (state_q == StWait && i_cmd_done && phase_q != PhStop)) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + 32'd1;
        end
    end

    assign timeout_hit = (tcnt_q >= TimeoutCycles - 32'd1);
`else
    logic unused_timeout;
    assign unused_timeout = |TimeoutCycles;
    assign timeout_hit    = 1'b0;
`endif

    // Pick the next command; a NACK on any WRITE jumps straight to STOP.
    always_comb begin
        is_nack   = i_cmd_nack && (o_cmd_op == OpWrite);
        nxt_phase = PhStop;
        nxt_idx   = 2'd0;
        case (phase_q)
            PhStart:   nxt_phase = PhAddrW;
            PhAddrW:   nxt_phase = is_nack ? PhStop : PhReg;
            PhReg:     nxt_phase = is_nack ? PhStop : (rd_q ? PhRestart : PhData);
            PhRestart: nxt_phase = PhAddrR;
            PhAddrR:   nxt_phase = is_nack ? PhStop : PhData;
            PhData: begin
                if (!is_nack && idx_q != burst_q) begin
                    nxt_phase = PhData;
                    nxt_idx   = idx_q + 2'd1;
                end
            end
            default:   nxt_phase = PhStop;
        endcase

        nxt_op    = OpStop;
        nxt_wdata = 8'h00;
        nxt_last  = 1'b0;
        case (nxt_phase)
            PhStart:   nxt_op = OpStart;
            PhAddrW:   begin nxt_op = OpWrite; nxt_wdata = {sa_q, 1'b0}; end
            PhReg:     begin nxt_op = OpWrite; nxt_wdata = reg_q; end
            PhRestart: nxt_op = OpRestart;
            PhAddrR:   begin nxt_op = OpWrite; nxt_wdata = {sa_q, 1'b1}; end
            PhData: begin
                if (rd_q) begin
                    nxt_op   = OpRead;
                    nxt_last = (nxt_idx == burst_q);
                end else begin
                    nxt_op    = OpWrite;
                    nxt_wdata = wdata_q[{nxt_idx, 3'b000} +: 8];
                end
            end
            default:   nxt_op = OpStop;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            phase_q     <= PhStart;
            idx_q       <= 2'd0;
            sa_q        <= 7'd0;
            reg_q       <= 8'd0;
            burst_q     <= 2'd0;
            wdata_q     <= 32'd0;
            rd_q        <= 1'b0;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= 1'b0;
            o_cmd_valid <= 1'b0;
            o_cmd_op    <= 3'd0;
            o_cmd_wdata <= 8'd0;
            o_cmd_last  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_req_valid && o_req_ready) begin
                        sa_q        <= i_req_slave_address;
                        reg_q       <= i_req_reg_address;
                        burst_q     <= i_req_burst_count;
                        wdata_q     <= i_req_wdata;
                        rd_q        <= i_req_rd_wrn;
                        phase_q     <= PhStart;
                        idx_q       <= 2'd0;
                        o_rsp_rdata <= 32'd0;
                        o_rsp_err   <= 1'b0;
                        o_cmd_valid <= 1'b1;
                        o_cmd_op    <= OpStart;
                        o_cmd_wdata <= 8'd0;
                        o_cmd_last  <= 1'b0;
                        o_req_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        state_q     <= StIssue;
                    end else begin
                        o_req_ready <= 1'b1;
                    end
                end
                StIssue, StWait: begin
                    if (timeout_hit) begin
                        o_cmd_valid <= 1'b0;
                        o_rsp_err   <= 1'b1;
                        o_rsp_valid <= 1'b1;
                        state_q     <= StResp;
                    end else if (state_q == StIssue) begin
                        if (i_cmd_ready) begin
                            o_cmd_valid <= 1'b0;
                            state_q     <= StWait;
                        end
                    end else if (i_cmd_done) begin
                        if (o_cmd_op == OpRead) begin
                            o_rsp_rdata[{idx_q, 3'b000} +: 8] <= i_cmd_rdata;
                        end
                        if (is_nack) begin
                            o_rsp_err <= 1'b1;
                        end
                        if (phase_q == PhStop) begin
                            o_rsp_valid <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            phase_q     <= nxt_phase;
                            idx_q       <= nxt_idx;
                            o_cmd_op    <= nxt_op;
                            o_cmd_wdata <= nxt_wdata;
                            o_cmd_last  <= nxt_last;
                            o_cmd_valid <= 1'b1;
                            state_q     <= StIssue;
                        end
                    end
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        o_busy      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_sequencer.sv
// Directed bench for i2c_req_sequencer: a small hand-driven byte engine plus per-scenario tasks.
module tb_i2c_req_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_sa = '0;
    logic [7:0]  req_reg = '0;
    logic [1:0]  req_burst = '0;
    logic [31:0] req_wdata = '0;
    logic        req_rd = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_wdata;
    logic        cmd_last;
    logic        cmd_done = 1'b0;
    logic [7:0]  cmd_rdata = '0;
    logic        cmd_nack = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    i2c_req_sequencer #(.TimeoutCycles(50)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_slave_address(req_sa), .i_req_reg_address(req_reg),
        .i_req_burst_count(req_burst), .i_req_wdata(req_wdata), .i_req_rd_wrn(req_rd),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
        .o_cmd_op(cmd_op), .o_cmd_wdata(cmd_wdata), .o_cmd_last(cmd_last),
        .i_cmd_done(cmd_done), .i_cmd_rdata(cmd_rdata), .i_cmd_nack(cmd_nack),
        .o_busy(busy)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [2:0] got_op[16];
    logic [7:0] got_wd[16];
    logic       got_last[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        cmd_ready = 1'b0; cmd_done = 1'b0; cmd_nack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_req(input logic [6:0] sa, input logic [7:0] ra, input logic [1:0] bc,
                            input logic [31:0] wd, input logic rd, output bit to);
        int n;
        n = 0; to = 1'b0;
        req_valid = 1'b1; req_sa = sa; req_reg = ra; req_burst = bc; req_wdata = wd; req_rd = rd;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (!req_ready) to = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Accepts and completes n commands; READs return successive bytes of rbytes.
    task automatic run_engine(input int n, input int nack_idx, input logic [31:0] rbytes,
                              output bit to);
        int rk;
        int w;
        rk = 0; to = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!cmd_valid && w < 50) begin tick(); w++; end
            if (!cmd_valid) begin to = 1'b1; return; end
            got_op[i] = cmd_op; got_wd[i] = cmd_wdata; got_last[i] = cmd_last;
            cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
            cmd_done = 1'b1;
            cmd_nack = (i == nack_idx);
            cmd_rdata = (rk < 4) ? rbytes[rk*8 +: 8] : 8'hEE;
            if (got_op[i] == 3'd3) rk++;
            tick();
            cmd_done = 1'b0; cmd_nack = 1'b0;
        end
    endtask

    task automatic get_rsp(output logic [31:0] rd, output logic er, output bit to);
        int n;
        n = 0; to = 1'b0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        if (!rsp_valid) to = 1'b1;
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0; tick();
        n_checks++; if ({req_ready, rsp_valid, rsp_err, cmd_valid, cmd_last, busy} !== 6'd0)
            $display("FAIL rst_flags: got %b want 000000",
                     {req_ready, rsp_valid, rsp_err, cmd_valid, cmd_last, busy}); else n_pass++;
        n_checks++; if ({rsp_rdata, cmd_op, cmd_wdata} !== 43'd0)
            $display("FAIL rst_data: got %h want 0", {rsp_rdata, cmd_op, cmd_wdata}); else n_pass++;
        rst_n = 1'b1; tick();
        n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL rst_release: got ready=%b busy=%b want 1 0", req_ready, busy); else n_pass++;
    endtask

    task automatic test_write();
        logic [2:0] eo[5] = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd4};
        logic [7:0] ew[5] = '{8'h00, 8'hE8, 8'h00, 8'h08, 8'h00};
        logic [31:0] rd; logic er; bit to;
        do_reset();
        send_req(7'h74, 8'h00, 2'd0, 32'h0000_0008, 1'b0, to);
        n_checks++; if (cmd_valid !== 1'b1 || to)
            $display("FAIL wr_first_cmd: got valid=%b want 1", cmd_valid); else n_pass++;
        run_engine(5, -1, 32'h0, to);
        n_checks++; if (to) $display("FAIL wr_engine_timeout: got stall want 5 cmds"); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (got_op[i] !== eo[i] || got_last[i] !== 1'b0 ||
                            (eo[i] == 3'd2 && got_wd[i] !== ew[i]))
                $display("FAIL wr_cmd[%0d]: got op=%0d wd=%h last=%b want op=%0d wd=%h last=0",
                         i, got_op[i], got_wd[i], got_last[i], eo[i], ew[i]); else n_pass++;
        end
        get_rsp(rd, er, to);
        n_checks++; if (to || rd !== 32'h0 || er !== 1'b0)
            $display("FAIL wr_rsp: got rdata=%h err=%b want 0 0", rd, er); else n_pass++;
        n_checks++; if (req_ready !== 1'b1)
            $display("FAIL wr_ready_after: got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_read();
        logic [2:0] eo[10] = '{3'd0, 3'd2, 3'd2, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        logic [7:0] ew[10] = '{8'h00, 8'hBA, 8'h07, 8'h00, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [31:0] rd; logic er; bit to;
        do_reset();
        send_req(7'h5D, 8'h07, 2'd3, 32'hFFFF_FFFF, 1'b1, to);
        run_engine(10, -1, 32'h0403_0201, to);
        n_checks++; if (to) $display("FAIL rd_engine_timeout: got stall want 10 cmds"); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (got_op[i] !== eo[i] || got_last[i] !== (i == 8) ||
                            (eo[i] == 3'd2 && got_wd[i] !== ew[i]))
                $display("FAIL rd_cmd[%0d]: got op=%0d wd=%h last=%b want op=%0d wd=%h last=%0d",
                         i, got_op[i], got_wd[i], got_last[i], eo[i], ew[i], (i == 8)); else n_pass++;
        end
        get_rsp(rd, er, to);
        n_checks++; if (to || rd !== 32'h0403_0201 || er !== 1'b0)
            $display("FAIL rd_rsp: got rdata=%h err=%b want 04030201 0", rd, er); else n_pass++;
    endtask

    task automatic test_nack();
        logic [31:0] rd; logic er; bit to;
        do_reset();
        send_req(7'h20, 8'h10, 2'd1, 32'h0000_AABB, 1'b0, to);
        run_engine(3, 1, 32'h0, to);
        n_checks++; if (to || got_op[1] !== 3'd2 || got_wd[1] !== 8'h40)
            $display("FAIL nack_addr: got op=%0d wd=%h want 2 40", got_op[1], got_wd[1]); else n_pass++;
        n_checks++; if (got_op[2] !== 3'd4)
            $display("FAIL nack_stop: got op=%0d want 4", got_op[2]); else n_pass++;
        get_rsp(rd, er, to);
        n_checks++; if (to || rd !== 32'h0 || er !== 1'b1)
            $display("FAIL nack_rsp: got rdata=%h err=%b want 0 1", rd, er); else n_pass++;
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] rd; logic er; bit to; bit bad; int n;
        do_reset();
        send_req(7'h33, 8'h44, 2'd0, 32'h0, 1'b1, to);
        req_valid = 1'b1; req_sa = 7'h11; req_rd = 1'b0; req_wdata = 32'h99;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_valid !== 1'b1 || cmd_op !== 3'd0 || cmd_wdata !== 8'd0 || cmd_last !== 1'b0 ||
                req_ready !== 1'b0) bad = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        n_checks++; if (bad) $display("FAIL stall_cmd: got unstable cmd/ready want held"); else n_pass++;
        run_engine(7, -1, 32'h0000_00C3, to);
        n_checks++; if (to || got_wd[1] !== 8'h66 || got_wd[4] !== 8'h67 || got_op[5] !== 3'd3 ||
                        got_last[5] !== 1'b1 || got_op[6] !== 3'd4)
            $display("FAIL stall_seq: got w1=%h w4=%h op5=%0d last5=%b op6=%0d want 66 67 3 1 4",
                     got_wd[1], got_wd[4], got_op[5], got_last[5], got_op[6]); else n_pass++;
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        req_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hC3 || rsp_err !== 1'b0 || req_ready !== 1'b0)
                bad = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        n_checks++; if (bad) $display("FAIL stall_rsp: got unstable rsp want held"); else n_pass++;
        get_rsp(rd, er, to);
        n_checks++; if (to || rd !== 32'hC3 || er !== 1'b0)
            $display("FAIL stall_rsp_val: got rdata=%h err=%b want c3 0", rd, er); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0)
            $display("FAIL stall_no_overlap: got busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to; bit bad; int w;
        do_reset();
        send_req(7'h5D, 8'h07, 2'd3, 32'h0, 1'b1, to);
        run_engine(7, -1, 32'h0403_0201, to);
        w = 0;
        while (!cmd_valid && w < 50) begin tick(); w++; end
        n_checks++; if (cmd_op !== 3'd3 || cmd_last !== 1'b0)
            $display("FAIL mid_third_read: got op=%0d last=%b want 3 0", cmd_op, cmd_last); else n_pass++;
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        rst_n = 1'b0; tick();
        n_checks++; if ({req_ready, rsp_valid, rsp_err, cmd_valid, cmd_last, busy} !== 6'd0 ||
                        {rsp_rdata, cmd_op, cmd_wdata} !== 43'd0)
            $display("FAIL mid_rst_outputs: got rdata=%h busy=%b op=%0d want all 0",
                     rsp_rdata, busy, cmd_op); else n_pass++;
        rst_n = 1'b1; tick();
        n_checks++; if (req_ready !== 1'b1)
            $display("FAIL mid_ready_after: got %b want 1", req_ready); else n_pass++;
        cmd_done = 1'b1; cmd_nack = 1'b1; tick(); cmd_done = 1'b0; cmd_nack = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (cmd_valid !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            tick();
        end
        n_checks++; if (bad) $display("FAIL mid_no_stop: got activity want idle"); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic er; bit to; int n;
        do_reset();
        send_req(7'h01, 8'h02, 2'd0, 32'h3, 1'b0, to);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
`ifdef I2C_REQ_SEQ_TIMEOUT_EN
        n = 0;
        while (!rsp_valid && n < 200) begin tick(); n++; end
        n_checks++; if (!rsp_valid || rsp_err !== 1'b1 || n < 45 || n > 55 || cmd_valid !== 1'b0)
            $display("FAIL timeout_rsp: got valid=%b err=%b after %0d cycles want 1 1 ~50",
                     rsp_valid, rsp_err, n); else n_pass++;
        get_rsp(rd, er, to);
        n_checks++; if (rd !== 32'h0 || req_ready !== 1'b1)
            $display("FAIL timeout_rdata: got %h want 0", rd); else n_pass++;
`else
        n = 0;
        while (n < 1000) begin tick(); n++; end
        n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || cmd_valid !== 1'b0)
            $display("FAIL no_timeout_wait: got busy=%b rsp=%b want 1 0", busy, rsp_valid); else n_pass++;
        cmd_done = 1'b1; tick(); cmd_done = 1'b0;
        run_engine(4, -1, 32'h0, to);
        get_rsp(rd, er, to);
        n_checks++; if (to || er !== 1'b0 || got_wd[3 - 1] !== 8'h03 || got_op[3] !== 3'd4)
            $display("FAIL no_timeout_finish: got err=%b wd=%h op=%0d want 0 03 4",
                     er, got_wd[2], got_op[3]); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_back_to_back_stall();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
